// File: rtl/address_fifo.sv
// rtl/address_fifo.sv - elastic address-word buffer ahead of address_fsm
//
// Circular buffer of DEPTH words with valid/ready handshakes on both sides.
// Words leave in FIFO order and are never dropped or duplicated.
//
// Optional feature macro: ADDRESS_FIFO_BYPASS_EN
//   When defined, a word offered to an empty buffer is presented on data_o in
//   the same cycle and, if the consumer takes it, never enters storage.
//
// Ports:
//   clk_i           rising-edge clock
//   arst_ni         synchronous active-low reset
//   data_i          word from the producer
//   data_i_valid_i  producer offers data_i
//   fifo_ready_o    buffer can accept a word this cycle
//   data_o          head word (zero when nothing to present)
//   data_o_valid_o  data_o is valid
//   rec_ready_i     consumer accepts data_o
//   count_o         number of stored words, 0..DEPTH

module address_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       data_i_valid_i,
    output logic                       fifo_ready_o,
    output logic [DATA_W-1:0]          data_o,
    output logic                       data_o_valid_o,
    input  logic                       rec_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic empty;
    logic push;
    logic pop;
    logic bypass_take;

    assign empty = (count == '0);

    // Ready depends on registered occupancy only, so a pop while full frees
    // the slot for the producer one cycle later, not combinationally.
    assign fifo_ready_o = (count != FULL);

`ifdef ADDRESS_FIFO_BYPASS_EN
    // Word handed straight through an empty buffer: consumed without storage.
    assign bypass_take = empty && data_i_valid_i && rec_ready_i;

    always_comb begin
        data_o         = '0;
        data_o_valid_o = 1'b0;
        if (!empty) begin
            data_o         = mem[rd_ptr];
            data_o_valid_o = 1'b1;
        end else if (data_i_valid_i) begin
            data_o         = data_i;
            data_o_valid_o = 1'b1;
        end
    end
`else
    assign bypass_take = 1'b0;

    always_comb begin
        data_o         = '0;
        data_o_valid_o = 1'b0;
        if (!empty) begin
            data_o         = mem[rd_ptr];
            data_o_valid_o = 1'b1;
        end
    end
`endif

    assign push = data_i_valid_i && fifo_ready_o && !bypass_take;
    // Only stored words are popped; the bypass path never touches rd_ptr.
    assign pop  = !empty && rec_ready_i;

    assign count_o = count;

    // Storage is not reset; contents behind a cleared count are never shown.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_address_fifo.sv
// tb/tb_address_fifo.sv - directed scoreboard bench for address_fifo

module tb_address_fifo;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;

    logic              clk_i = 1'b0;
    logic              arst_ni;
    logic [DATA_W-1:0] data_i;
    logic              data_i_valid_i;
    logic              fifo_ready_o;
    logic [DATA_W-1:0] data_o;
    logic              data_o_valid_o;
    logic              rec_ready_i;
    logic [2:0]        count_o;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] q[$];
    int mcount = 0;

    address_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk_i          (clk_i),
        .arst_ni        (arst_ni),
        .data_i         (data_i),
        .data_i_valid_i (data_i_valid_i),
        .fifo_ready_o   (fifo_ready_o),
        .data_o         (data_o),
        .data_o_valid_o (data_o_valid_o),
        .rec_ready_i    (rec_ready_i),
        .count_o        (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model and the clock.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic rr);
        logic              exp_ready;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_data;
        logic              do_push;
        logic              do_pop;
        logic [DATA_W-1:0] want;
        data_i_valid_i = v;
        data_i         = d;
        rec_ready_i    = rr;
        #1;
        exp_ready = (mcount != DEPTH);
        exp_valid = (mcount != 0);
        exp_data  = (mcount != 0) ? q[0] : '0;
`ifdef ADDRESS_FIFO_BYPASS_EN
        if (mcount == 0 && v) begin
            exp_valid = 1'b1;
            exp_data  = d;
        end
`endif
        chk("fifo_ready", 32'(fifo_ready_o), 32'(exp_ready));
        chk("data_valid", 32'(data_o_valid_o), 32'(exp_valid));
        chk("data_o", 32'(data_o), 32'(exp_data));
        chk("count", 32'(count_o), 32'(mcount));
        do_push = v && exp_ready;
        do_pop  = (mcount != 0) && rr;
`ifdef ADDRESS_FIFO_BYPASS_EN
        if (mcount == 0 && v && rr) begin
            do_push = 1'b0;
            chk("bypass_word", 32'(data_o), 32'(d));
        end
`endif
        if (do_pop) begin
            want = q.pop_front();
            chk("popped_word", 32'(data_o), 32'(want));
        end
        if (do_push) q.push_back(d);
        mcount = mcount + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_cycle(input logic v, input logic [DATA_W-1:0] d);
        arst_ni        = 1'b0;
        data_i_valid_i = v;
        data_i         = d;
        rec_ready_i    = 1'b0;
        @(posedge clk_i);
        #1;
        q.delete();
        mcount = 0;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(fifo_ready_o), 32'd1);
`ifdef ADDRESS_FIFO_BYPASS_EN
        chk("rst_valid", 32'(data_o_valid_o), 32'(v));
        chk("rst_data", 32'(data_o), v ? 32'(d) : 32'd0);
`else
        chk("rst_valid", 32'(data_o_valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
`endif
        arst_ni = 1'b1;
    endtask

    initial begin
        int i;
        int k;
        arst_ni        = 1'b0;
        data_i         = '0;
        data_i_valid_i = 1'b0;
        rec_ready_i    = 1'b0;
        #1;

        // Reset held two cycles with a word offered: nothing stored.
        reset_cycle(1'b1, 16'hABCD);
        reset_cycle(1'b1, 16'hABCD);
        cycle(1'b0, 16'h0000, 1'b0);

        // Fill to full, hold off a fifth word, then drain.
        cycle(1'b1, 16'hABCD, 1'b0);
        cycle(1'b1, 16'hCAFE, 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b0);
        cycle(1'b1, 16'hBEEF, 1'b0);
        cycle(1'b1, 16'hF00D, 1'b0);
        cycle(1'b1, 16'hF00D, 1'b0);
        cycle(1'b1, 16'hF00D, 1'b1);
        cycle(1'b1, 16'hF00D, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);

        // Simultaneous push and pop at occupancy 2.
        cycle(1'b1, 16'h1111, 1'b0);
        cycle(1'b1, 16'h2222, 1'b0);
        cycle(1'b1, 16'h3333, 1'b1);
        cycle(1'b1, 16'h4444, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);

        // Wrap-around streaming with alternating consumer ready.
        i = 0;
        k = 0;
        while (i < 10 && k < 100) begin
            logic acc;
            acc = (mcount != DEPTH);
            cycle(1'b1, 16'(i), (k % 2) == 0);
            if (acc) i++;
            k++;
        end
        k = 0;
        while (mcount != 0 && k < 50) begin
            cycle(1'b0, 16'h0000, (k % 2) == 0);
            k++;
        end
        chk("stream_drained", 32'(q.size()), 32'd0);

        // Reset mid-operation at occupancy 3.
        cycle(1'b1, 16'hAAAA, 1'b0);
        cycle(1'b1, 16'hBBBB, 1'b0);
        cycle(1'b1, 16'hCCCC, 1'b0);
        chk("pre_reset_count", 32'(count_o), 32'd3);
        reset_cycle(1'b0, 16'h0000);
        cycle(1'b1, 16'h1234, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0);

        // Word into an empty buffer with consumer ready.
        cycle(1'b1, 16'h5A5A, 1'b1);
`ifndef ADDRESS_FIFO_BYPASS_EN
        chk("nobypass_count_pulse", 32'(count_o), 32'd1);
`endif
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/address_fifo.md
# address_fifo

Elastic buffer directly upstream of `address_fsm`. It absorbs 16-bit address words from the producer and presents them to `address_fsm` under a valid/ready handshake, so `address_fsm` can hold `fsm_ready_o` low while it serialises a word into nibbles without stalling the producer. Words leave in strict FIFO order, are never dropped, and are never duplicated.

## Interface
Parameters:
- `DEPTH`, default 4: number of storage entries; must be a power of two and at least 2.
- `DATA_W`, default 16: word width; must match the `address_fsm` `data_i` width.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `arst_ni`  in  1  reset: one clock; reset is synchronous and active-low.
- `data_i`  in  DATA_W  word from the producer.
- `data_i_valid_i`  in  1  producer offers `data_i`.
- `fifo_ready_o`  out  1  buffer can accept a word this cycle.
- `data_o`  out  DATA_W  head word; connects to `address_fsm` `data_i`.
- `data_o_valid_o`  out  1  `data_o` is valid; connects to `address_fsm` `data_i_valid_i`.
- `rec_ready_i`  in  1  consumer accepts `data_o`; connects to `address_fsm` `fsm_ready_o`.
- `count_o`  out  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.

## Operation
- Storage: circular array `mem[DEPTH]`, `wr_ptr` and `rd_ptr` of width $clog2(DEPTH), and an occupancy counter `count` of width $clog2(DEPTH)+1.
- Push: occurs when `data_i_valid_i && fifo_ready_o`. The word is written to `mem[wr_ptr]`, then `wr_ptr` increments modulo DEPTH.
- Pop: occurs when `data_o_valid_o && rec_ready_i`. `rd_ptr` increments modulo DEPTH.
- `count` update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- `fifo_ready_o = (count != DEPTH)`. It is decoded from registered state only and has no combinational path from `rec_ready_i`.
- `data_o_valid_o = (count != 0)`.
- `data_o = mem[rd_ptr]` when `count != 0`, otherwise all zeros.
- `count_o = count`.
- Boundary conditions:
  - Full (`count == DEPTH`): `fifo_ready_o` = 0. A word offered that cycle is not taken. The producer holds it until ready returns.
  - A pop while full frees one entry. `fifo_ready_o` rises on the next cycle, not the same cycle.
  - Empty (`count == 0`): `data_o_valid_o` = 0 and `rec_ready_i` is ignored. No pop and no underflow can occur.
  - Push and pop in the same cycle at 0 < count < DEPTH: both take effect and `count` is unchanged.
  - Pointer wrap-around: from DEPTH−1 to 0. Ordering is preserved across the wrap.
  - `data_i` or `data_i_valid_i` changing while `fifo_ready_o` = 0 has no effect on state.

## Timing
- Reset: while `arst_ni` = 0 at a rising edge, `count`, `wr_ptr` and `rd_ptr` clear to 0.
  - Reset has priority over a push or pop in the same cycle.
  - `mem` contents are not cleared.
- Output values after reset: `data_o_valid_o` = 0, `data_o` = 0, `count_o` = 0, `fifo_ready_o` = 1.
- Reset mid-operation: all stored words are discarded. The next edge with `arst_ni` = 1 behaves as from empty.
- Latency without bypass: a word pushed at edge N appears on `data_o` with `data_o_valid_o` = 1 after edge N, i.e. in cycle N+1. It is consumable at edge N+1 at the earliest.
- Throughput: one push and one pop per cycle, sustained, for any occupancy 1..DEPTH−1.

## Configuration
- Macro: `ADDRESS_FIFO_BYPASS_EN`.
- Defined: when `count == 0` and `data_i_valid_i` = 1:
  - `data_o` = `data_i` and `data_o_valid_o` = 1, combinationally in the same cycle.
  - If `rec_ready_i` = 1 that cycle, the word is consumed directly. It is not written and `count` stays 0.
  - If `rec_ready_i` = 0, the word is pushed normally and `count` becomes 1.
  - `count_o` excludes a word in flight on the bypass path.
- Not defined: no path from `data_i` to `data_o`. Minimum latency is one cycle as stated in Timing.

## Test plan
- Reset values: hold `arst_ni` = 0 for 2 cycles with `data_i_valid_i` = 1 and `data_i` = 16'hABCD. Required: `count_o` = 0, `data_o_valid_o` = 0, `data_o` = 0 and `fifo_ready_o` = 1 throughout; the word is not stored.
- Fill and drain with `DEPTH` = 4 and `rec_ready_i` = 0:
  - Push ABCD, CAFE, DEAD, BEEF. Required: `count_o` steps 1→4, and `fifo_ready_o` = 0 after the 4th push.
  - Then offer F00D with `rec_ready_i` still 0. Required: F00D is held off and `count_o` stays 4.
  - Then raise `rec_ready_i`. Required: `data_o` shows ABCD, CAFE, DEAD, BEEF on consecutive cycles, then F00D; `fifo_ready_o` returns to 1 one cycle after the first pop.
- Simultaneous push and pop at `count_o` = 2: `count_o` stays 2 and output order is unchanged.
- Wrap-around streaming: 10 words 16'h0000..16'h0009 with `rec_ready_i` toggling 1,0,1,0,…. Required: all 10 words are received in order, with no loss and no duplicates.
- Reset mid-operation at `count_o` = 3: on the next edge `count_o` = 0 and `data_o_valid_o` = 0. A subsequent push of 16'h1234 is the first word out.
- Bypass, with `ADDRESS_FIFO_BYPASS_EN` defined, empty buffer and `rec_ready_i` = 1: push 16'h5A5A. Required: `data_o` = 16'h5A5A with `data_o_valid_o` = 1 in the same cycle, and `count_o` stays 0. Without the macro, the word appears one cycle later and `count_o` pulses to 1.
